iiitb_mem_responder: RTL and testbench



---
 rtl/iiitb_mem_responder.sv | 109 ++++++++++
 tb/tb_iiitb_mem_responder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/iiitb_mem_responder.sv
// rtl/iiitb_mem_responder.sv - wait-state memory responder for the toy processor load/store port
module iiitb_mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              mem_err,
    output logic              busy,
    output logic [15:0]       xact_count
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]      WAIT_LD   = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

    state_t              state, state_nxt;
    logic [3:0]          wait_cnt, wait_nxt;
    logic                we_q, oob_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                capture, enter_ack, eff_we, eff_oob;
    logic [ADDR_W-1:0]   eff_addr;
    logic [DATA_W-1:0]   ram [DEPTH];

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_req) begin
                    capture   = 1'b1;
                    wait_nxt  = WAIT_LD;
                    state_nxt = (WAIT_LD == 4'd0) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                wait_nxt = wait_cnt - 4'd1;
                if (wait_cnt <= 4'd1) begin
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // With zero wait states the ACK entry coincides with capture, so use the live inputs then.
    always_comb begin
        eff_we    = capture ? mem_we   : we_q;
        eff_addr  = capture ? mem_addr : addr_q;
        eff_oob   = ({1'b0, eff_addr} >= DEPTH_LIM);
        enter_ack = (state != ST_ACK) && (state_nxt == ST_ACK);
        mem_ack   = (state == ST_ACK);
        mem_err   = (state == ST_ACK) && oob_q;
        busy      = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= 4'd0;
            we_q       <= 1'b0;
            oob_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_rdata  <= '0;
            xact_count <= 16'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (capture) begin
                we_q    <= mem_we;
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                oob_q   <= eff_oob;
            end
            if (enter_ack) begin
                if (eff_oob) begin
                    mem_rdata <= '0;
                end else if (!eff_we) begin
                    mem_rdata <= ram[eff_addr[IDX_W-1:0]];
                end
            end
            if (state == ST_ACK) begin
                xact_count <= xact_count + 16'd1;
            end
        end
    end

    // RAM is not reset; a reset during WAIT/ACK forces IDLE so the write never fires.
    always_ff @(posedge clk) begin
        if (state == ST_ACK && we_q && !oob_q) begin
            ram[addr_q[IDX_W-1:0]] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_iiitb_mem_responder.sv
// tb/tb_iiitb_mem_responder.sv - directed self-checking bench for iiitb_mem_responder
module tb_iiitb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  addr = '0;
    logic [15:0] wdata = '0;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic [15:0] rdata_a, rdata_b, cnt_a, cnt_b;
    logic        ack_a, ack_b, err_a, err_b, busy_a, busy_b;

    logic        sel = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          r_lat;
    logic [15:0] r_rdata, r_cnt;
    logic        r_err, r_busy, r_ack_after;

    always #5 clk = ~clk;

    iiitb_mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(2)) u_a (
        .clk(clk), .rst(rst), .mem_req(req_a), .mem_we(we), .mem_addr(addr),
        .mem_wdata(wdata), .mem_rdata(rdata_a), .mem_ack(ack_a), .mem_err(err_a),
        .busy(busy_a), .xact_count(cnt_a));

    iiitb_mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .rst(rst), .mem_req(req_b), .mem_we(we), .mem_addr(addr),
        .mem_wdata(wdata), .mem_rdata(rdata_b), .mem_ack(ack_b), .mem_err(err_b),
        .busy(busy_b), .xact_count(cnt_b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the selected responder idle; returns at a negedge after the ack cycle.
    task automatic run_xact(input logic s, input logic w, input logic [7:0] a,
                            input logic [15:0] d, input logic scramble);
        sel = s; we = w; addr = a; wdata = d;
        if (s) req_b = 1'b1; else req_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (scramble) begin
            we = ~w; addr = a + 8'd1; wdata = ~d;
        end
        r_lat = 0;
        while (!(s ? ack_b : ack_a) && r_lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            r_lat++;
        end
        r_rdata = s ? rdata_b : rdata_a;
        r_err   = s ? err_b : err_a;
        r_busy  = s ? busy_b : busy_a;
        req_a = 1'b0; req_b = 1'b0;
        @(posedge clk);
        @(negedge clk);
        r_cnt       = s ? cnt_b : cnt_a;
        r_ack_after = s ? ack_b : ack_a;
    endtask

    initial begin
        int acks, last;
        repeat (2) @(negedge clk);
        check("rst_ack", ack_a, 0);
        check("rst_err", err_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_rdata", rdata_a, 16'h0);
        check("rst_cnt", cnt_a, 16'h0);
        rst = 1'b1;
        @(negedge clk);

        run_xact(0, 1, 8'h10, 16'hBEEF, 0);
        check("wr_lat", r_lat, 2);
        check("wr_err", r_err, 0);
        check("wr_busy", r_busy, 1);
        check("wr_ack_pulse", r_ack_after, 0);
        run_xact(0, 0, 8'h10, 16'h0000, 0);
        check("rd_data", r_rdata, 16'hBEEF);
        check("rd_err", r_err, 0);
        check("rd_cnt", r_cnt, 16'd2);

        run_xact(0, 1, 8'h00, 16'h5A5A, 0);
        run_xact(0, 1, 8'hC8, 16'h1234, 0);
        check("oob_err", r_err, 1);
        check("oob_rdata", r_rdata, 16'h0);
        run_xact(0, 0, 8'h00, 16'h0000, 0);
        check("oob_keep", r_rdata, 16'h5A5A);
        check("oob_keep_err", r_err, 0);

        run_xact(0, 1, 8'h21, 16'h3333, 0);
        run_xact(0, 1, 8'h20, 16'h1111, 1);
        run_xact(0, 0, 8'h20, 16'h0000, 0);
        check("cap_addr20", r_rdata, 16'h1111);
        run_xact(0, 0, 8'h21, 16'h0000, 0);
        check("cap_addr21", r_rdata, 16'h3333);
        check("cap_cnt", r_cnt, 16'd9);

        run_xact(0, 1, 8'h05, 16'h7777, 0);
        sel = 0; we = 1; addr = 8'h05; wdata = 16'hAAAA; req_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_busy", busy_a, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", busy_a, 0);
        check("arst_ack", ack_a, 0);
        check("arst_err", err_a, 0);
        check("arst_rdata", rdata_a, 16'h0);
        check("arst_cnt", cnt_a, 16'h0);
        req_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_xact(0, 0, 8'h05, 16'h0000, 0);
        check("arst_old", r_rdata, 16'h7777);
        check("arst_cnt_after", r_cnt, 16'd1);

        run_xact(1, 1, 8'h03, 16'h0042, 0);
        check("w0_wr_lat", r_lat, 0);
        run_xact(1, 0, 8'h03, 16'h0000, 0);
        check("w0_rd_lat", r_lat, 0);
        check("w0_rd_data", r_rdata, 16'h0042);

        sel = 1; we = 0; addr = 8'h03; req_b = 1'b1;
        acks = 0; last = 0;
        for (int c = 0; c < 20 && acks < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack_b) begin
                acks++;
                if (acks > 1) check("b2b_gap", c - last, 2);
                check("b2b_data", rdata_b, 16'h0042);
                last = c;
                if (acks == 4) req_b = 1'b0;
            end
        end
        req_b = 1'b0;
        check("b2b_acks", acks, 4);
        @(posedge clk);
        @(negedge clk);
        check("b2b_cnt", cnt_b, 16'd6);

        force u_b.xact_count = 16'hFFFF;
        @(negedge clk);
        release u_b.xact_count;
        run_xact(1, 0, 8'h03, 16'h0000, 0);
        check("wrap_cnt", r_cnt, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
